// File: rtl/cpu_defs.sv
// cpu_defs: shared core widths, fetch FSM state type and fetch buffer entry type.
package cpu_defs;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
   typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry prefetch buffer of {pc, inst} pairs.
// Ports: clk, rst (async, active-high); push/wr_entry write the tail;
// pop retires the head; flush empties the buffer (wins over push/pop);
// count is the occupancy 0..2; head is the oldest entry, zero when empty.
module fetch_fifo
   import cpu_defs::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_entry,
   output logic [1:0]   count,
   output fetch_entry_t head
);
   fetch_entry_t mem [2];
   logic         rd;
   logic         wr;

   assign head = (count != 2'd0) ? mem[rd] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem   <= '{default: '0};
         rd    <= 1'b0;
         wr    <= 1'b0;
         count <= 2'd0;
      end else if (flush) begin
         rd    <= 1'b0;
         wr    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[wr] <= wr_entry;
            wr      <= ~wr;
         end
         if (pop)
            rd <= ~rd;
         // push and pop together leave the occupancy unchanged, even when full
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: sequential instruction fetch with redirect, halt and a 2-entry prefetch buffer.
// Ports: clk, rst (async, active-high); inst_mem_addr/inst_mem_valid/inst_mem_data
// form the same-cycle ROM interface; redirect_valid/redirect_pc retarget fetch;
// halt stops new fetches; if_valid/if_ready/if_pc/if_inst is the decode handshake.
module inst_fetch
   import cpu_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
   parameter int              FIFO_DEPTH = 2
)(
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] inst_mem_addr,
   output logic            inst_mem_valid,
   input  logic [ILEN-1:0] inst_mem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [ILEN-1:0] if_inst
);
   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [1:0]      count;
   fetch_entry_t    head;
   logic            fire;

   assign if_valid      = count != 2'd0;
   assign fire          = if_valid && if_ready;
   assign inst_mem_addr = pc;
   assign if_pc         = head.pc;
   assign if_inst       = head.inst;
   // a full buffer may still accept a word when decode drains its head this cycle
   assign inst_mem_valid = (state == RUN) && !redirect_valid &&
                           ((32'(count) < FIFO_DEPTH) || fire);

   fetch_fifo u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inst_mem_valid),
      .pop      (fire),
      .flush    (redirect_valid),
      .wr_entry ('{pc: pc, inst: inst_mem_data}),
      .count    (count),
      .head     (head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= (state == BOOT) ? RUN : (halt ? HALT : RUN);
         // redirect targets are forced word-aligned; pc+4 wraps naturally at 2^64
         pc    <= redirect_valid ? (redirect_pc & ~64'h3) :
                  inst_mem_valid ? pc + 64'd4 : pc;
      end
   end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the prefetch buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port inst_mem_addr  output  64  meaning the fetch address to the instruction ROM.
REQ-006 SHALL have port inst_mem_valid  output  1  meaning the fetch request (ROM chip-enable).
REQ-007 SHALL have port inst_mem_data  input  32  meaning the ROM word, combinationally valid in the same cycle as the request.
REQ-008 SHALL have port redirect_valid  input  1  meaning a branch/jump/trap redirect from the core.
REQ-009 SHALL have port redirect_pc  input  64  meaning the new fetch target.
REQ-010 SHALL have port halt  input  1  meaning stop issuing new fetches.
REQ-011 SHALL have port if_valid  output  1  meaning an instruction is offered to decode.
REQ-012 SHALL have port if_ready  input  1  meaning decode accepts the offered instruction.
REQ-013 SHALL have port if_pc  output  64  meaning the PC of the offered instruction.
REQ-014 SHALL have port if_inst  output  32  meaning the offered instruction word.

Function
REQ-015 SHALL implement FSM states BOOT, RUN and HALT; reset enters BOOT, BOOT→RUN after one cycle, RUN→HALT while halt=1, HALT→RUN when halt=0.
REQ-016 SHALL assert inst_mem_valid only in RUN, when redirect_valid=0 and the FIFO has space (count<2, or count==2 with a same-cycle pop).
REQ-017 SHALL drive inst_mem_addr = pc at all times, and SHALL push {pc, inst_mem_data} and set pc <= pc+4 on every edge where inst_mem_valid=1.
REQ-018 SHALL give a fetch-to-offer latency of 1 cycle: a word fetched in cycle N appears on if_valid in cycle N+1 at the earliest.
REQ-019 SHALL assert if_valid = (count!=0), with if_pc/if_inst taken from the FIFO head, and SHALL drive if_pc=0 and if_inst=0 when the FIFO is empty.
REQ-020 SHALL pop the FIFO head on if_valid && if_ready, and SHALL allow a push and a pop in the same cycle when count==2, keeping count at 2.
REQ-021 SHALL, on redirect_valid=1, clear the FIFO on the next edge, load pc <= {redirect_pc[63:2], 2'b00}, and hold inst_mem_valid=0 in that cycle.
REQ-022 SHALL treat a handshake occurring in the same cycle as a redirect as completed, and SHALL clear all remaining entries.
REQ-023 SHALL let a redirect during HALT or BOOT update pc while issuing no fetch.
REQ-024 SHALL wrap pc from 64'hFFFF_FFFF_FFFF_FFFC to 64'h0 modulo 2^64.
REQ-025 SHALL keep the FIFO contents and continue offering them while halt=1.

Reset
REQ-026 SHALL, on rst=1 asynchronously, set pc=RESET_PC, count=0, FIFO pointers=0 and state=BOOT, forcing if_valid=0, inst_mem_valid=0, if_pc=0 and if_inst=0.
REQ-027 SHALL, on reset mid-operation, discard all buffered instructions with no partial handshake visible afterward.

Structure
REQ-028 SHALL use XLEN=64, ILEN=32, the fetch FSM state typedef and NOP=32'h00000013 from the shared package cpu_defs.
REQ-029 SHALL place the 2-entry FIFO (push, pop, flush, count, head) in the sub-module fetch_fifo.

Verification
REQ-030 Reset sequence: rst high 195 ns then low → first inst_mem_valid one cycle after BOOT with addr 0x0, then addrs 0x4 and 0x8 on consecutive cycles.
REQ-031 Back-pressure: if_ready=0 → exactly 2 fetches (0x0, 0x4) followed by inst_mem_valid=0; raising if_ready delivers 0x0, 0x4, 0x8 in order with no loss or duplication.
REQ-032 Redirect: redirect_valid=1 with redirect_pc=0x103 while 2 entries are buffered → FIFO empty next cycle, the next fetch is at 0x100, and the next offered if_pc is 0x100.
REQ-033 Simultaneous events: redirect and handshake in one cycle → the head is counted as consumed, and no stale PC appears afterward.
REQ-034 Halt: halt=1 for 5 cycles with if_ready=1 → buffered entries drain, no fetches occur, and fetching resumes at the next sequential PC.
REQ-035 Wrap and reset: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → the second fetch is at 0x0; asserting rst mid-stream → if_valid=0 immediately (asynchronously).
